sramlike_arbiter: RTL and testbench
===================================

SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk  in  1  clock`; `rst  in  1  asynchronous active-low reset`.
REQ-002 The instruction-side master port SHALL be: `i_req in 1`, `i_wr in 1`, `i_size in 2`, `i_addr in 32`, `i_wdata in 32`, `i_addr_ok out 1`, `i_data_ok out 1`, `i_rdata out 32`.
REQ-003 The data-side master port SHALL be the same set of signals with the `d_` prefix (`d_req` ... `d_rdata`), with identical directions and widths.
REQ-004 The shared slave port SHALL be: `req out 1`, `wr out 1`, `size out 2`, `addr out 32`, `wdata out 32`, `addr_ok in 1`, `data_ok in 1`, `rdata in 32`.
REQ-005 The block SHALL expose `busy  out  1  high whenever FSM != IDLE`.

Function
REQ-006 The FSM SHALL have three states: IDLE, ADDR and DATA; at most one transaction SHALL be outstanding on the slave.
REQ-007 In IDLE, if `i_req` or `d_req` is high, the FSM SHALL record the grant (INST or DATA) and go to ADDR on the next cycle; it SHALL stay in IDLE otherwise.
REQ-008 Grant selection SHALL be fixed priority, with DATA winning over INST when both request in the same cycle (default build).
REQ-009 In ADDR, `req`, `wr`, `size`, `addr` and `wdata` SHALL be driven combinationally from the granted master; the other master's fields SHALL be ignored.
REQ-010 In ADDR, when `req && addr_ok`, the block SHALL assert the granted master's `*_addr_ok` in that same cycle, register `wr`, and go to DATA.
REQ-011 In ADDR, if the granted master's `*_req` is low (request withdrawn), the block SHALL drive `req` low and return to IDLE next cycle without any ok pulse.
REQ-012 In DATA, `req` SHALL be 0; on `data_ok`, the block SHALL pulse the granted master's `*_data_ok` for exactly one cycle (same cycle as `data_ok`) and return to IDLE.
REQ-013 `i_rdata` and `d_rdata` SHALL both be the registered copy of `rdata`, captured on `data_ok` in DATA; they SHALL hold their value until the next capture.
REQ-014 A `data_ok` received in IDLE or ADDR SHALL be ignored: no master pulse and no rdata capture.
REQ-015 Write transactions SHALL follow the same path; the master's `*_data_ok` SHALL mark write completion and rdata SHALL be captured but is meaningless for writes.
REQ-016 The non-granted master's `*_addr_ok` and `*_data_ok` SHALL be 0 at all times.
REQ-017 Minimum latency SHALL be: request in IDLE at cycle 0, `addr_ok` at cycle 1 at the earliest, `data_ok` at cycle 2 at the earliest, back-to-back issue from IDLE at cycle 3.

Reset
REQ-018 Asserting `rst` low SHALL force, asynchronously: state = IDLE, grant = INST, last-grant = INST, rdata register = 0.
REQ-019 While in reset, outputs SHALL be `req` = 0, all `*_addr_ok` / `*_data_ok` = 0, `busy` = 0, and `i_rdata` / `d_rdata` = 0.
REQ-020 A reset asserted mid-transaction SHALL abandon the transaction with no ok pulse; any late `data_ok` after reset SHALL be ignored per REQ-014.

Configuration
REQ-021 The macro `SRAMLIKE_ARB_RR_EN` SHALL, when defined, make grant round-robin: on a simultaneous request, the master not granted last wins, and last-grant SHALL update on each IDLE->ADDR transition.
REQ-022 Without `SRAMLIKE_ARB_RR_EN`, there SHALL be no last-grant register and grant SHALL be fixed DATA-priority per REQ-008.

Structure
REQ-023 A shared package `sramlike_pkg` SHALL hold the FSM state typedef (IDLE/ADDR/DATA), the grant typedef (INST/DATA) and size constants (`SIZE_B` = 0, `SIZE_H` = 1, `SIZE_W` = 2).
REQ-024 Grant selection SHALL be a sub-module `sramlike_arb_pick`, with inputs `i_req`, `d_req` and last-grant, and output the grant; it is purely combinational.

Verification
REQ-025 Single inst read: `i_req` with `addr` 0xBFC00000; slave `addr_ok` at cycle 1 and `data_ok` with `rdata` 0x3C1D0001 at cycle 2 -> `i_addr_ok` at cycle 1, `i_data_ok` at cycle 2, `i_rdata` = 0x3C1D0001 from cycle 3, `d_*_ok` always 0.
REQ-026 Simultaneous `i_req` and `d_req` (data write 0xDEADBEEF to 0x80001000, size 2), default build -> data granted first and slave sees `wr` = 1; inst granted at the next IDLE.
REQ-027 Same stimulus as REQ-026 with `SRAMLIKE_ARB_RR_EN` after a prior DATA grant -> INST granted first.
REQ-028 `d_req` dropped in ADDR before `addr_ok` -> `req` = 0 the same cycle, IDLE next cycle, no `d_addr_ok` / `d_data_ok`.
REQ-029 `rst` pulsed low in DATA, then `data_ok` = 1 one cycle after release -> no master `data_ok`, rdata register stays 0.
REQ-030 Slave holds `addr_ok` low for 5 cycles -> `req` and the granted fields stay stable, `busy` = 1 throughout.

Source files
------------

// File: rtl/sramlike_pkg.sv
// sramlike_pkg: shared FSM state, grant and transfer size definitions for the SRAM-like arbiter.
package sramlike_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  // Grant literals carry a prefix because DATA is already taken by the state enum.
  typedef enum logic {GNT_INST, GNT_DATA} grant_t;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
endpackage

// File: rtl/sramlike_arb_pick.sv
// sramlike_arb_pick: combinational grant choice; on a tie the master not granted last wins.
module sramlike_arb_pick
  import sramlike_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last,
  output grant_t grant
);
  assign grant = (i_req && d_req) ? ((last == GNT_INST) ? GNT_DATA : GNT_INST)
               : (d_req ? GNT_DATA : GNT_INST);
endmodule

// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter: two SRAM-like masters (inst/data) sharing one slave, one outstanding transaction.
// SRAMLIKE_ARB_RR_EN selects round-robin grant; otherwise DATA has fixed priority.
module sramlike_arbiter
  import sramlike_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        busy
);
  state_t      state;
  grant_t      grant, pick, last;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        is_d, g_req, fin;
  assign is_d  = grant == GNT_DATA;
  assign g_req = is_d ? d_req : i_req;
  assign req   = (state == ADDR) && g_req;
  assign wr    = (state == ADDR) ? (is_d ? d_wr : i_wr) : wr_q;
  assign size  = is_d ? d_size : i_size;
  assign addr  = is_d ? d_addr : i_addr;
  assign wdata = is_d ? d_wdata : i_wdata;
  assign i_addr_ok = req && addr_ok && !is_d;
  assign d_addr_ok = req && addr_ok && is_d;
  assign fin       = (state == DATA) && data_ok;
  assign i_data_ok = fin && !is_d;
  assign d_data_ok = fin && is_d;
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign busy      = state != IDLE;
`ifdef SRAMLIKE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) last <= GNT_INST;
    else if (state == IDLE && (i_req || d_req)) last <= pick;
`else
  // A constant INST history turns the picker's tie-break into fixed DATA priority.
  assign last = GNT_INST;
`endif
  sramlike_arb_pick u_pick (.i_req(i_req), .d_req(d_req), .last(last), .grant(pick));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      grant   <= GNT_INST;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else
      case (state)
        IDLE: if (i_req || d_req) begin
          state <= ADDR;
          grant <= pick;
        end
        ADDR: if (!g_req) state <= IDLE;
          else if (addr_ok) begin
            state <= DATA;
            wr_q  <= wr;
          end
        DATA: if (data_ok) begin
          state   <= IDLE;
          rdata_q <= rdata;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sramlike_arbiter.sv
// tb_sramlike_arbiter: scenario tasks plus a scoreboard of expected master data_ok pulses and rdata.
module tb_sramlike_arbiter;
  import sramlike_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic i_req, i_wr, d_req, d_wr, addr_ok, data_ok;
  logic [1:0] i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, rdata;
  logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, req, wr, busy;
  logic [1:0] size;
  logic [31:0] i_rdata, d_rdata, addr, wdata;
  int total = 0, passed = 0;
  typedef struct {logic side; logic [31:0] rdata;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic pend = 1'b0;
  logic [31:0] pend_val, model_rdata = '0;

  sramlike_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every master data_ok pulse must match the next expected entry, rdata follows a cycle later.
  always @(negedge clk) begin
    #2;
    if (pend) begin
      total++;
      if (i_rdata !== pend_val || d_rdata !== pend_val)
        $display("FAIL rdata_capture i_rdata=%h d_rdata=%h expected %h", i_rdata, d_rdata, pend_val);
      else passed++;
      pend = 1'b0;
    end
    if (i_data_ok || d_data_ok) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL spurious_data_ok i_data_ok=%b d_data_ok=%b expected none", i_data_ok, d_data_ok);
      else begin
        e = exp_q.pop_front();
        if ({i_data_ok, d_data_ok} !== (e.side ? 2'b01 : 2'b10))
          $display("FAIL data_ok_side {i,d}=%b expected %b", {i_data_ok, d_data_ok}, e.side ? 2'b01 : 2'b10);
        else passed++;
        pend = 1'b1;
        pend_val = e.rdata;
      end
    end
  end

  task cyc;
    @(negedge clk);
  endtask

  task clr;
    {i_req, i_wr, d_req, d_wr, addr_ok, data_ok} = '0;
    {i_size, d_size} = '0;
    {i_addr, i_wdata, d_addr, d_wdata, rdata} = '0;
  endtask

  task push(input logic side, input logic [31:0] val);
    exp_q.push_back('{side, val});
    model_rdata = val;
  endtask

  task test_reset;
    clr;
    rst = 1'b0;
    cyc;
    i_req = 1'b1; d_req = 1'b1; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
    cyc; #1;
    total++; if ({req, busy} !== 2'b00) $display("FAIL reset_req_busy {req,busy}=%b expected 00", {req, busy}); else passed++;
    total++; if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0)
      $display("FAIL reset_oks oks=%b expected 0000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); else passed++;
    total++; if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata i=%h d=%h expected 0", i_rdata, d_rdata); else passed++;
    cyc;
    clr;
    rst = 1'b1;
  endtask

  task test_inst_read;
    cyc;
    i_req = 1'b1; i_addr = 32'hBFC0_0000; i_size = SIZE_W; #1;
    total++; if ({req, busy} !== 2'b00) $display("FAIL inst_idle {req,busy}=%b expected 00", {req, busy}); else passed++;
    cyc; #1;
    total++; if ({req, busy, wr, addr} !== {3'b110, 32'hBFC0_0000})
      $display("FAIL inst_addr req=%b busy=%b wr=%b addr=%h expected 1 1 0 bfc00000", req, busy, wr, addr); else passed++;
    addr_ok = 1'b1; #1;
    total++; if ({i_addr_ok, d_addr_ok} !== 2'b10) $display("FAIL inst_addr_ok {i,d}=%b expected 10", {i_addr_ok, d_addr_ok}); else passed++;
    cyc;
    i_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3C1D_0001;
    push(1'b0, 32'h3C1D_0001); #1;
    total++; if ({req, busy} !== 2'b01) $display("FAIL inst_data_phase {req,busy}=%b expected 01", {req, busy}); else passed++;
    cyc;
    clr; #1;
    total++; if (busy !== 1'b0) $display("FAIL inst_done busy=%b expected 0", busy); else passed++;
  endtask

  task test_simultaneous(input logic inst_first);
    cyc;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 32'hBFC0_0004; i_size = SIZE_W; i_wdata = '0;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_1000; d_size = SIZE_W; d_wdata = 32'hDEAD_BEEF;
    cyc; #1;
    total++;
    if ({req, wr, size, addr, wdata} !== (inst_first ? {2'b10, SIZE_W, 32'hBFC0_0004, 32'h0}
                                                     : {2'b11, SIZE_W, 32'h8000_1000, 32'hDEAD_BEEF}))
      $display("FAIL first_grant req=%b wr=%b size=%0d addr=%h wdata=%h inst_first=%b", req, wr, size, addr, wdata, inst_first);
    else passed++;
    addr_ok = 1'b1; #1;
    total++; if ({i_addr_ok, d_addr_ok} !== {inst_first, !inst_first})
      $display("FAIL first_addr_ok {i,d}=%b expected %b", {i_addr_ok, d_addr_ok}, {inst_first, !inst_first}); else passed++;
    cyc;
    if (inst_first) i_req = 1'b0; else d_req = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_0000;
    push(!inst_first, 32'h1111_0000);
    cyc;
    data_ok = 1'b0;
    cyc; #1;
    total++;
    if ({req, wr, addr} !== (inst_first ? {2'b11, 32'h8000_1000} : {2'b10, 32'hBFC0_0004}))
      $display("FAIL second_grant req=%b wr=%b addr=%h inst_first=%b", req, wr, addr, inst_first);
    else passed++;
    addr_ok = 1'b1; #1;
    total++; if ({i_addr_ok, d_addr_ok} !== {!inst_first, inst_first})
      $display("FAIL second_addr_ok {i,d}=%b expected %b", {i_addr_ok, d_addr_ok}, {!inst_first, inst_first}); else passed++;
    cyc;
    i_req = 1'b0; d_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2222_0000;
    push(inst_first, 32'h2222_0000);
    cyc;
    clr;
  endtask

  task test_data_only;
    cyc;
    d_req = 1'b1; d_addr = 32'h8000_2000; d_size = SIZE_H;
    cyc;
    addr_ok = 1'b1; #1;
    total++; if ({i_addr_ok, d_addr_ok, size} !== {2'b01, SIZE_H})
      $display("FAIL data_only_addr_ok {i,d}=%b size=%0d expected 01 1", {i_addr_ok, d_addr_ok}, size); else passed++;
    cyc;
    d_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3333_0000;
    push(1'b1, 32'h3333_0000);
    cyc;
    clr;
  endtask

  task test_withdraw;
    cyc;
    d_req = 1'b1; d_addr = 32'h8000_3000;
    cyc; #1;
    total++; if (req !== 1'b1) $display("FAIL withdraw_req_before req=%b expected 1", req); else passed++;
    d_req = 1'b0; addr_ok = 1'b1; #1;
    total++; if ({req, busy, i_addr_ok, d_addr_ok} !== 4'b0100)
      $display("FAIL withdraw_same_cycle req=%b busy=%b i_addr_ok=%b d_addr_ok=%b expected 0 1 0 0", req, busy, i_addr_ok, d_addr_ok);
    else passed++;
    cyc;
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hAAAA_5555; #1;
    total++; if (busy !== 1'b0) $display("FAIL withdraw_idle busy=%b expected 0", busy); else passed++;
    cyc;
    clr; #1;
    total++; if (d_rdata !== model_rdata) $display("FAIL idle_data_ok_ignored d_rdata=%h expected %h", d_rdata, model_rdata); else passed++;
  endtask

  task test_reset_mid;
    cyc;
    i_req = 1'b1; i_addr = 32'hBFC0_0010;
    cyc;
    addr_ok = 1'b1;
    cyc;
    i_req = 1'b0; addr_ok = 1'b0; #1;
    total++; if (busy !== 1'b1) $display("FAIL mid_in_data busy=%b expected 1", busy); else passed++;
    rst = 1'b0; model_rdata = '0; #1;
    total++; if ({busy, req, i_rdata} !== 34'h0) $display("FAIL mid_async_reset busy=%b req=%b i_rdata=%h expected 0", busy, req, i_rdata); else passed++;
    cyc;
    rst = 1'b1;
    cyc;
    data_ok = 1'b1; rdata = 32'h55AA_55AA; #1;
    total++; if ({i_data_ok, d_data_ok} !== 2'b00) $display("FAIL late_data_ok {i,d}=%b expected 00", {i_data_ok, d_data_ok}); else passed++;
    cyc;
    clr; #1;
    total++; if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL late_rdata i=%h d=%h expected 0", i_rdata, d_rdata); else passed++;
  endtask

  task test_back_to_back;
    cyc;
    i_req = 1'b1; i_wr = 1'b1; i_addr = 32'hBFC0_0020; i_size = SIZE_H; i_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 5; k++) begin
      cyc; #1;
      total++;
      if ({req, busy, wr, i_addr_ok, size, addr, wdata} !== {4'b1110, SIZE_H, 32'hBFC0_0020, 32'hCAFE_F00D})
        $display("FAIL stall_%0d req=%b busy=%b wr=%b i_addr_ok=%b size=%0d addr=%h wdata=%h", k, req, busy, wr, i_addr_ok, size, addr, wdata);
      else passed++;
    end
    cyc;
    addr_ok = 1'b1; #1;
    total++; if (i_addr_ok !== 1'b1) $display("FAIL stall_addr_ok i_addr_ok=%b expected 1", i_addr_ok); else passed++;
    cyc;
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h4444_0000;
    push(1'b0, 32'h4444_0000); #1;
    total++; if (wr !== 1'b1) $display("FAIL write_wr_held wr=%b expected 1", wr); else passed++;
    cyc;
    data_ok = 1'b0; #1;
    total++; if ({req, busy} !== 2'b00) $display("FAIL b2b_idle {req,busy}=%b expected 00", {req, busy}); else passed++;
    cyc; #1;
    total++; if ({req, busy} !== 2'b11) $display("FAIL b2b_reissue {req,busy}=%b expected 11", {req, busy}); else passed++;
    i_req = 1'b0;
    cyc; #1;
    total++; if (busy !== 1'b0) $display("FAIL b2b_withdraw busy=%b expected 0", busy); else passed++;
    clr;
  endtask

  initial begin
    test_reset;
    test_inst_read;
    test_simultaneous(1'b0);
    test_data_only;
`ifdef SRAMLIKE_ARB_RR_EN
    test_simultaneous(1'b1);
`else
    test_simultaneous(1'b0);
`endif
    test_withdraw;
    test_reset_mid;
    test_back_to_back;
    cyc;
    cyc;
    total++;
    if (exp_q.size() != 0) $display("FAIL missing_data_ok pending=%0d expected 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
